// File: rtl/cernbe_initiator.sv
// CERN-BE register-bus initiator: turns a valid/ready command into one
// VMERdMem/VMEWrMem cycle and returns data or a timeout error on a response pulse.
module cernbe_initiator #(
    parameter int unsigned ADDR_MSB = 19,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic              Clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_MSB:2] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_MSB:2] VMEAddr,
    output logic [31:0]       VMEWrData,
    output logic              VMERdMem,
    output logic              VMEWrMem,
    input  logic [31:0]       VMERdData,
    input  logic              VMERdDone,
    input  logic              VMEWrDone
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_WAIT = 2'd1;
    localparam logic [1:0] WR_WAIT = 2'd2;

    localparam int unsigned CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned CNT_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam bit          TO_EN    = (TIMEOUT != 0);

    logic [1:0]          state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [ADDR_MSB:2]   addr_d;
    logic [31:0]         wdata_d;
    logic                rdmem_d, wrmem_d;
    logic                rsp_valid_d, rsp_err_d;
    logic [31:0]         rsp_rdata_d;
    logic                expired;
    logic                done_match;
    logic [31:0]         done_data;

    assign cmd_ready = (state == IDLE);

    // Expiry fires on the TIMEOUT-th wait cycle; counter starts at 0 in the strobe cycle.
    assign expired = TO_EN && (cnt == CNT_W'(CNT_LAST));

    // Matching completion for the access type currently outstanding.
    always_comb begin
        done_match = 1'b0;
        done_data  = 32'd0;
        if (state == RD_WAIT) begin
            done_match = VMERdDone;
            done_data  = VMERdData;
        end else if (state == WR_WAIT) begin
            done_match = VMEWrDone;
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        addr_d      = VMEAddr;
        wdata_d     = VMEWrData;
        rdmem_d     = 1'b0;
        wrmem_d     = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d = cmd_addr;
                    cnt_d  = '0;
                    if (cmd_we) begin
                        wdata_d = cmd_wdata;
                        wrmem_d = 1'b1;
                        state_d = WR_WAIT;
                    end else begin
                        rdmem_d = 1'b1;
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT, WR_WAIT: begin
                // A done arriving in the expiry cycle takes priority over the error.
                if (done_match) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = done_data;
                    rsp_err_d   = 1'b0;
                    state_d     = IDLE;
                end else if (expired) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = 1'b1;
                    state_d     = IDLE;
                end else if (TO_EN) begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            VMEAddr   <= '0;
            VMEWrData <= 32'd0;
            VMERdMem  <= 1'b0;
            VMEWrMem  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            VMEAddr   <= addr_d;
            VMEWrData <= wdata_d;
            VMERdMem  <= rdmem_d;
            VMEWrMem  <= wrmem_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
        end
    end

endmodule
